// File: rtl/uart16550_pkg.sv
// uart16550_pkg: shared definitions for the uart16550 host engine.
//   - peripheral register addresses, LSR bit indices, init values
//   - host FSM state encoding
//   - byte-lane pack/unpack helpers for the 32-bit register bus
package uart16550_pkg;

  // Register addresses (3-bit word address on the peripheral bus)
  localparam logic [2:0] RBR_THR = 3'd0;
  localparam logic [2:0] IER_DLM = 3'd1;
  localparam logic [2:0] IIR_FCR = 3'd2;
  localparam logic [2:0] LCR     = 3'd3;
  localparam logic [2:0] MCR     = 3'd4;
  localparam logic [2:0] LSR     = 3'd5;
  localparam logic [2:0] MSR     = 3'd6;
  localparam logic [2:0] SCR     = 3'd7;

  // LSR bit positions
  localparam int LSR_DR   = 0;
  localparam int LSR_OE   = 1;
  localparam int LSR_THRE = 5;
  localparam int LSR_TEMT = 6;

  // Configuration values
  localparam logic [7:0] LCR_DLAB = 8'h83;  // 8N1 with divisor latch open
  localparam logic [7:0] LCR_8N1  = 8'h03;
  localparam logic [7:0] FCR_RST  = 8'h07;  // enable + clear both FIFOs
  localparam logic [7:0] FCR_EN   = 8'h01;  // enable, RX trigger level 1

  typedef enum logic [3:0] {
    ST_INIT_LCR_DL,
    ST_INIT_DLL,
    ST_INIT_DLM,
    ST_INIT_LCR,
    ST_INIT_FCR_RST,
    ST_INIT_FCR_EN,
    ST_INIT_IER,
    ST_POLL,
    ST_RX_READ,
    ST_TX_WRITE
  } state_e;

  // Place a byte in the selected lane; every other bit is zero.
  function automatic logic [31:0] lane_pack(input logic [7:0] b, input logic lendian);
    return lendian ? {24'h0, b} : {b, 24'h0};
  endfunction

  // Extract the selected lane; the remaining read-data bits are ignored.
  function automatic logic [7:0] lane_unpack(input logic [31:0] w, input logic lendian);
    return lendian ? w[7:0] : w[31:24];
  endfunction

endpackage

// File: rtl/uart16550_host.sv
// uart16550_host: bus initiator that configures a uart16550 and then moves
// bytes between two valid/ready streams and the THR/RBR registers.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   a, d, rd, we        register bus request (held until ready)
//   spo, ready          register bus read data / completion
//   tx_valid/ready/data byte stream into the UART
//   rx_valid/ready/data byte stream out of the UART
//   init_done           configuration sequence finished
//   overrun             sticky, LSR.OE observed since reset
module uart16550_host
  import uart16550_pkg::*;
#(
  parameter int CLOCK_FREQ = 62500000,
  parameter int BAUD_RATE  = 115200,
  parameter int LENDIAN    = 0,
  parameter int TX_BURST   = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic [2:0]  a,
  output logic [31:0] d,
  output logic        rd,
  output logic        we,
  input  logic [31:0] spo,
  input  logic        ready,
  input  logic        tx_valid,
  input  logic [7:0]  tx_data,
  output logic        tx_ready,
  output logic        rx_valid,
  output logic [7:0]  rx_data,
  input  logic        rx_ready,
  output logic        init_done,
  output logic        overrun
);

  localparam int DIV = CLOCK_FREQ / (16 * BAUD_RATE);
  localparam logic [15:0] DIV_W = 16'(DIV);
  localparam logic LANE_LO = (LENDIAN != 0);

  if (DIV < 1 || DIV > 65535) begin : g_bad_div
    $error("uart16550_host: divisor out of range 1..65535");
  end
  if (TX_BURST < 1 || TX_BURST > 16) begin : g_bad_burst
    $error("uart16550_host: TX_BURST out of range 1..16");
  end

  state_e      state_q, state_d;
  logic        run_q, hold_q, hold_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        rx_valid_q, rx_valid_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        init_done_q, init_done_d;
  logic        overrun_q, overrun_d;
  logic [7:0]  rd_byte;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the values computed before the edge, independent of order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_INIT_LCR_DL;
      run_q       <= 1'b0;
      hold_q      <= 1'b0;
      cnt_q       <= '0;
      rx_valid_q  <= 1'b0;
      rx_data_q   <= '0;
      init_done_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_q       <= 1'b1;   // keeps the bus idle for one cycle after reset
      hold_q      <= hold_d;
      cnt_q       <= cnt_d;
      rx_valid_q  <= rx_valid_d;
      rx_data_q   <= rx_data_d;
      init_done_q <= init_done_d;
      overrun_q   <= overrun_d;
    end
  end

  // Bus request is a function of state only, except the THR write, which
  // carries the live tx byte and is suppressed when no byte is offered at
  // the start of a write (hold_q keeps a started write alive).
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // through the case can infer a latch.
    a  = '0;
    d  = '0;
    rd = 1'b0;
    we = 1'b0;
    if (run_q) begin
      unique case (state_q)
        ST_INIT_LCR_DL:  begin a = LCR;     d = lane_pack(LCR_DLAB, LANE_LO);    we = 1'b1; end
        ST_INIT_DLL:     begin a = RBR_THR; d = lane_pack(DIV_W[7:0], LANE_LO);  we = 1'b1; end
        ST_INIT_DLM:     begin a = IER_DLM; d = lane_pack(DIV_W[15:8], LANE_LO); we = 1'b1; end
        ST_INIT_LCR:     begin a = LCR;     d = lane_pack(LCR_8N1, LANE_LO);     we = 1'b1; end
        ST_INIT_FCR_RST: begin a = IIR_FCR; d = lane_pack(FCR_RST, LANE_LO);     we = 1'b1; end
        ST_INIT_FCR_EN:  begin a = IIR_FCR; d = lane_pack(FCR_EN, LANE_LO);      we = 1'b1; end
        ST_INIT_IER:     begin a = IER_DLM; d = lane_pack(8'h00, LANE_LO);       we = 1'b1; end
        ST_POLL:         begin a = LSR;     rd = 1'b1; end
        ST_RX_READ:      begin a = RBR_THR; rd = 1'b1; end
        ST_TX_WRITE: begin
          a  = RBR_THR;
          d  = lane_pack(tx_data, LANE_LO);
          we = tx_valid || hold_q;
        end
        default: ;
      endcase
    end
  end

  assign rd_byte = lane_unpack(spo, LANE_LO);

  always_comb begin
    state_d     = state_q;
    hold_d      = 1'b0;
    cnt_d       = cnt_q;
    rx_valid_d  = rx_valid_q;
    rx_data_d   = rx_data_q;
    init_done_d = init_done_q;
    overrun_d   = overrun_q;

    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

    if (run_q) begin
      unique case (state_q)
        ST_INIT_LCR_DL:  if (ready) state_d = ST_INIT_DLL;
        ST_INIT_DLL:     if (ready) state_d = ST_INIT_DLM;
        ST_INIT_DLM:     if (ready) state_d = ST_INIT_LCR;
        ST_INIT_LCR:     if (ready) state_d = ST_INIT_FCR_RST;
        ST_INIT_FCR_RST: if (ready) state_d = ST_INIT_FCR_EN;
        ST_INIT_FCR_EN:  if (ready) state_d = ST_INIT_IER;
        ST_INIT_IER: if (ready) begin
          state_d     = ST_POLL;
          init_done_d = 1'b1;
        end
        ST_POLL: if (ready) begin
          if (rd_byte[LSR_OE]) overrun_d = 1'b1;
          // RBR is only dequeued when the holding register is free.
          if (rd_byte[LSR_DR] && !rx_valid_q) begin
            state_d = ST_RX_READ;
          end else if (rd_byte[LSR_THRE] && tx_valid) begin
            cnt_d   = 5'(TX_BURST);
            state_d = ST_TX_WRITE;
          end
        end
        ST_RX_READ: if (ready) begin
          rx_data_d  = rd_byte;
          rx_valid_d = 1'b1;
          state_d    = ST_POLL;
        end
        ST_TX_WRITE: begin
          if (!we) begin
            state_d = ST_POLL;
          end else if (ready) begin
            cnt_d = (cnt_q == 5'd0) ? 5'd0 : cnt_q - 5'd1;
            if (cnt_d == 5'd0) state_d = ST_POLL;
          end else begin
            hold_d = 1'b1;
          end
        end
        default: state_d = ST_INIT_LCR_DL;
      endcase
    end
  end

  assign tx_ready  = (state_q == ST_TX_WRITE) && ready;
  assign rx_valid  = rx_valid_q;
  assign rx_data   = rx_data_q;
  assign init_done = init_done_q;
  assign overrun   = overrun_q;

endmodule
